irq_ctrl: RTL and testbench



---
 rtl/irq_ctrl_pkg.sv | 28 ++
 rtl/platform_pkg.sv | 9 +
 rtl/wishbone_if.sv | 28 ++
 rtl/irq_ctrl_prio_enc.sv | 24 ++
 rtl/irq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 208 ++++++++++++++++++++
 6 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register map, source slots and shared helpers
// for the external interrupt controller.
package irq_ctrl_pkg;

    localparam int NUM_IRQ_SRC = 8;
    localparam int IRQ_ID_W    = 5;

    localparam logic [2:0] IRQ_PENDING_OFF  = 3'd0;
    localparam logic [2:0] IRQ_ENABLE_OFF   = 3'd1;
    localparam logic [2:0] IRQ_EDGE_SEL_OFF = 3'd2;
    localparam logic [2:0] IRQ_CLAIM_OFF    = 3'd3;
    localparam logic [2:0] IRQ_COMPLETE_OFF = 3'd4;

    localparam int IRQ_SRC_UART_RX     = 0;
    localparam int IRQ_SRC_UART_TX     = 1;
    localparam int IRQ_SRC_UART_RXFIFO = 2;
    localparam int IRQ_SRC_UART_TXFIFO = 3;

    // Expand 4 byte selects into a 32-bit write mask.
    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/platform_pkg.sv
// platform_pkg: crossbar slave slot assignment for the
// interrupt controller.
package platform_pkg;

    localparam int          IRQ_CTRL_SLAVE_INDEX = 4;
    localparam logic [31:0] IRQ_CTRL_BASE_ADDR   = 32'h4000_4000;
    localparam logic [31:0] IRQ_CTRL_ADDR_MASK   = 32'hFFFF_F000;

endpackage

// File: rtl/wishbone_if.sv
// wishbone_if: pipelined Wishbone bundle with master and
// slave views; addr is a word address.
interface wishbone_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW/8-1:0] sel;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rdata;
    logic            ack;
    logic            stall;
    logic            err;
    logic            rty;

    modport MASTER (
        output cyc, stb, we, addr, sel, wdata,
        input  rdata, ack, stall, err, rty
    );

    modport SLAVE (
        input  cyc, stb, we, addr, sel, wdata,
        output rdata, ack, stall, err, rty
    );
endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder.
// id is index+1; id 0 means no request.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = NUM_IRQ_SRC
) (
    input  logic [NUM_SRC-1:0]  req,
    output logic                valid,
    output logic [IRQ_ID_W-1:0] id
);

    // Scan downwards so the lowest set index is written last.
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = IRQ_ID_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: Wishbone external interrupt controller with
// pending/enable/edge-select registers and claim/complete.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int                 NUM_SRC      = NUM_IRQ_SRC,
    parameter logic [NUM_SRC-1:0] RST_EDGE_SEL = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    wishbone_if.SLAVE          wb_if,
    input  logic [NUM_SRC-1:0] src_i,
    output logic               irq_o
);

    logic [NUM_SRC-1:0]  pending;
    logic [NUM_SRC-1:0]  enable;
    logic [NUM_SRC-1:0]  edge_sel;
    logic [NUM_SRC-1:0]  src_q;
    logic                busy;
    logic [IRQ_ID_W-1:0] claimed_id;
    logic                ack;
    logic [31:0]         rdata;

    logic                req;
    logic                rd;
    logic                wr;
    logic [2:0]          off;
    logic [NUM_SRC-1:0]  wmask;
    logic [NUM_SRC-1:0]  wbits;
    logic [NUM_SRC-1:0]  active;
    logic                act_valid;
    logic [IRQ_ID_W-1:0] act_id;
    logic                claim_ok;
    logic                complete_ok;
    logic [NUM_SRC-1:0]  claim_clr;
    logic [NUM_SRC-1:0]  w1c;
    logic [NUM_SRC-1:0]  rise;
    logic [NUM_SRC-1:0]  pend_next;
    logic [31:0]         rdata_d;
    logic                unused_bits;

    assign req   = wb_if.cyc & wb_if.stb;
    assign rd    = req & ~wb_if.we;
    assign wr    = req & wb_if.we;
    assign off   = wb_if.addr[2:0];
    assign wmask = NUM_SRC'(sel_to_mask(wb_if.sel));
    assign wbits = wb_if.wdata[NUM_SRC-1:0];

    assign wb_if.ack   = ack;
    assign wb_if.rdata = rdata;
    assign wb_if.stall = 1'b0;
    assign wb_if.err   = 1'b0;
    assign wb_if.rty   = 1'b0;

    assign unused_bits = ^{wb_if.addr, wb_if.wdata};

    assign active = pending & enable;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_enc (
        .req   (active),
        .valid (act_valid),
        .id    (act_id)
    );

    assign claim_ok = rd & (off == IRQ_CLAIM_OFF)
                    & ~busy & act_valid;

    assign complete_ok = wr & (off == IRQ_COMPLETE_OFF)
                       & wb_if.sel[0] & busy
                       & (wb_if.wdata[IRQ_ID_W-1:0] == claimed_id);

    assign w1c = (wr & (off == IRQ_PENDING_OFF) & wb_if.sel[0])
               ? wbits : '0;

    assign rise = src_i & ~src_q;

    // One-hot clear for the source being claimed.
    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_clr[i] = claim_ok
                         && (act_id == IRQ_ID_W'(i + 1));
        end
    end

    // Edge sources hold until cleared; a new edge beats a clear.
    // Level sources simply follow their line.
    assign pend_next =
        (edge_sel & (rise | (pending & ~(w1c | claim_clr))))
      | (~edge_sel & src_i);

    // Read data mux; zero outside read cycles.
    always_comb begin
        rdata_d = '0;
        if (rd) begin
            unique case (off)
                IRQ_PENDING_OFF:  rdata_d = 32'(pending);
                IRQ_ENABLE_OFF:   rdata_d = 32'(enable);
                IRQ_EDGE_SEL_OFF: rdata_d = 32'(edge_sel);
                IRQ_CLAIM_OFF:    rdata_d = claim_ok
                                          ? 32'(act_id) : '0;
                default:          rdata_d = '0;
            endcase
        end
    end

    // Bus response: one-cycle ack with registered data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= req;
            rdata <= rdata_d;
        end
    end

    // Source sampling and pending state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q   <= '0;
            pending <= '0;
        end else begin
            src_q   <= src_i;
            pending <= pend_next;
        end
    end

    // Software-writable enable and edge-select registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable   <= '0;
            edge_sel <= RST_EDGE_SEL;
        end else begin
            if (wr && off == IRQ_ENABLE_OFF) begin
                enable <= (enable & ~wmask) | (wbits & wmask);
            end
            if (wr && off == IRQ_EDGE_SEL_OFF) begin
                edge_sel <= (edge_sel & ~wmask)
                          | (wbits & wmask);
            end
        end
    end

    // Claim/complete handshake tracking the in-service source.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy       <= 1'b0;
            claimed_id <= '0;
        end else if (claim_ok) begin
            busy       <= 1'b1;
            claimed_id <= act_id;
        end else if (complete_ok) begin
            busy       <= 1'b0;
        end
    end

    // Registered request to the core.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= ~busy & (|active);
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] src;
    logic       irq;
    int         n_cmp = 0;
    int         n_err = 0;

    logic [31:0] d;
    logic        a;

    wishbone_if wb ();

    always #5 clk = ~clk;

    irq_ctrl #(
        .NUM_SRC      (8),
        .RST_EDGE_SEL (8'h80)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb_if (wb),
        .src_i (src),
        .irq_o (irq)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        wb.cyc   = 1'b0;
        wb.stb   = 1'b0;
        wb.we    = 1'b0;
        wb.addr  = '0;
        wb.sel   = '0;
        wb.wdata = '0;
    endtask

    task automatic wb_rd(input  logic [2:0]  off,
                         output logic [31:0] data,
                         output logic        ackd);
        @(negedge clk);
        wb.cyc  = 1'b1;
        wb.stb  = 1'b1;
        wb.we   = 1'b0;
        wb.addr = {29'd0, off};
        wb.sel  = 4'hF;
        @(negedge clk);
        bus_idle();
        data = wb.rdata;
        ackd = wb.ack;
    endtask

    task automatic wb_wr(input logic [2:0]  off,
                         input logic [31:0] data,
                         input logic [3:0]  sel);
        @(negedge clk);
        wb.cyc   = 1'b1;
        wb.stb   = 1'b1;
        wb.we    = 1'b1;
        wb.addr  = {29'd0, off};
        wb.sel   = sel;
        wb.wdata = data;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic rd_chk(input string tag,
                          input logic [2:0] off,
                          input logic [31:0] exp);
        logic [31:0] v;
        logic        k;
        wb_rd(off, v, k);
        chk(tag, v, exp);
    endtask

    initial begin
        rst = 1'b1;
        src = '0;
        bus_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state and ack latency
        chk("rst_irq", {31'd0, irq}, 32'd0);
        for (int o = 0; o < 8; o++) begin
            wb_rd(3'(o), d, a);
            chk("rst_rd", d, (o == 2) ? 32'h80 : 32'h0);
            chk("ack_lat", {31'd0, a}, 32'd1);
        end
        wb_rd(3'd2, d, a);
        chk("edge_rd", d, 32'h80);
        @(negedge clk);
        chk("ack_drop", {31'd0, wb.ack}, 32'd0);
        chk("rdata_idle", wb.rdata, 32'd0);

        // edge source 0: latency, claim, complete
        wb_wr(3'd1, 32'h01, 4'hF);
        wb_wr(3'd2, 32'h01, 4'hF);
        @(negedge clk);
        src = 8'h01;
        @(negedge clk);
        src = 8'h00;
        chk("e_irq1", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("e_irq2", {31'd0, irq}, 32'd1);
        rd_chk("e_pend", 3'd0, 32'h01);
        rd_chk("e_claim", 3'd3, 32'd1);
        @(negedge clk);
        chk("e_irq_drop", {31'd0, irq}, 32'd0);
        rd_chk("e_pend_clr", 3'd0, 32'h00);
        rd_chk("e_claim2", 3'd3, 32'd0);
        wb_wr(3'd4, 32'd1, 4'hF);

        // level sources 2 and 3, wrong and right complete
        wb_wr(3'd1, 32'h0C, 4'hF);
        src = 8'h0C;
        repeat (2) @(negedge clk);
        chk("l_irq", {31'd0, irq}, 32'd1);
        rd_chk("l_claim", 3'd3, 32'd3);
        @(negedge clk);
        chk("l_irq_busy", {31'd0, irq}, 32'd0);
        wb_wr(3'd4, 32'd4, 4'hF);
        @(negedge clk);
        chk("l_bad_cmp", {31'd0, irq}, 32'd0);
        wb_wr(3'd4, 32'd3, 4'hF);
        @(negedge clk);
        chk("l_good_cmp", {31'd0, irq}, 32'd1);
        src = 8'h00;

        // edge set beats a same-cycle W1C
        wb_wr(3'd2, 32'h02, 4'hF);
        @(negedge clk);
        src      = 8'h02;
        wb.cyc   = 1'b1;
        wb.stb   = 1'b1;
        wb.we    = 1'b1;
        wb.addr  = 32'd0;
        wb.sel   = 4'hF;
        wb.wdata = 32'h02;
        @(negedge clk);
        bus_idle();
        rd_chk("w1c_race", 3'd0, 32'h02);
        wb_wr(3'd0, 32'h02, 4'hF);
        rd_chk("w1c_clr", 3'd0, 32'h00);
        src = 8'h00;

        // masked source 5, byte selects, enable latency
        wb_wr(3'd2, 32'h00, 4'hF);
        src = 8'h20;
        repeat (2) @(negedge clk);
        chk("m_irq", {31'd0, irq}, 32'd0);
        rd_chk("m_pend", 3'd0, 32'h20);
        rd_chk("m_claim", 3'd3, 32'd0);
        wb_wr(3'd1, 32'hFF, 4'h0);
        rd_chk("m_sel0", 3'd1, 32'h0C);
        wb_wr(3'd1, 32'h20, 4'hF);
        chk("m_en_lat0", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("m_en_lat1", {31'd0, irq}, 32'd1);
        rd_chk("m_claim6", 3'd3, 32'd6);

        // pipelined reads cut by reset
        @(negedge clk);
        wb.cyc  = 1'b1;
        wb.stb  = 1'b1;
        wb.we   = 1'b0;
        wb.sel  = 4'hF;
        wb.addr = 32'd1;
        @(negedge clk);
        chk("p_ack1", {31'd0, wb.ack}, 32'd1);
        chk("p_rd1", wb.rdata, 32'h20);
        wb.addr = 32'd2;
        rst     = 1'b1;
        @(negedge clk);
        chk("p_ack2", {31'd0, wb.ack}, 32'd0);
        wb.addr = 32'd0;
        @(negedge clk);
        chk("p_ack3", {31'd0, wb.ack}, 32'd0);
        chk("p_irq", {31'd0, irq}, 32'd0);
        bus_idle();
        rst = 1'b0;
        @(negedge clk);
        chk("p_ack4", {31'd0, wb.ack}, 32'd0);
        rd_chk("p_en", 3'd1, 32'h00);
        rd_chk("p_edge", 3'd2, 32'h80);
        wb_wr(3'd1, 32'h20, 4'hF);
        @(negedge clk);
        chk("p_busy_clr", {31'd0, irq}, 32'd1);
        rd_chk("p_claim", 3'd3, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
